// File: rtl/i2c_pkg.sv
// Purpose: shared I2C definitions (bus field widths, target FSM state encoding)
//          so the target and the master core can agree on them.
// Ports:   none (package).
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned BYTE_W     = 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK
  } i2c_state_t;

  // True when the upper 7 bits of an address byte select the given target.
  function automatic logic addr_match(input logic [BYTE_W-1:0]     i_byte,
                                      input logic [I2C_ADDR_W-1:0] i_addr);
    return i_byte[BYTE_W-1:1] == i_addr;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Purpose: synchronise an asynchronous I2C pad input and reject glitches.
//          A new level is accepted only after FILTER consecutive equal samples.
// Ports:
//   aclk     in  clock
//   areset   in  asynchronous active-high reset (output resets to idle-high)
//   i_pad    in  raw pad level
//   o_level  out filtered level
module i2c_in_filter #(
  parameter int unsigned FILTER = 3
) (
  input  logic aclk,
  input  logic areset,
  input  logic i_pad,
  output logic o_level
);

  localparam int unsigned CNT_W = $clog2(FILTER + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser followed by a run-length counter on differing samples.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILTER - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/i2c_target_regs.sv
// Purpose: I2C target with a byte register file shared with a local host.
//          Write transfer: first byte loads the register pointer, later bytes
//          write registers with auto-increment. Read transfer streams registers
//          from the pointer. START/STOP are honoured in every state.
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   scl_in, sda_in        asynchronous bus inputs
//   sda_oe                1 = pull SDA low
//   host_addr/wdata/we    local host write port (index uses low log2(DEPTH) bits)
//   host_rdata            regs[host_addr], combinational
//   busy                  set on address match, cleared by STOP or address NACK
//   wr_pulse, wr_index    one-cycle strobe and index of each I2C register write
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int unsigned           DEPTH       = 16,
  parameter int unsigned           FILTER      = 3
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [BYTE_W-1:0] host_addr,
  input  logic [BYTE_W-1:0] host_wdata,
  input  logic              host_we,
  output logic [BYTE_W-1:0] host_rdata,
  output logic              busy,
  output logic              wr_pulse,
  output logic [BYTE_W-1:0] wr_index
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  logic w_scl;
  logic w_sda;
  logic r_scl_q;
  logic r_sda_q;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  i2c_state_t        r_state;
  i2c_state_t        w_state_nxt;
  logic              r_sda_oe;
  logic              w_sda_oe_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [CNT_W-1:0]  w_bitcnt_nxt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] w_shift_nxt;
  logic [BYTE_W-2:0] r_tx;
  logic [BYTE_W-2:0] w_tx_nxt;
  logic              r_rw;
  logic              w_rw_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              r_wr_pulse;
  logic [BYTE_W-1:0] r_wr_index;
  logic [BYTE_W-1:0] w_wr_index_nxt;
  logic              w_commit;
  logic              w_rd_load;
  logic [BYTE_W-1:0] w_rd_data;
  logic [PTR_W-1:0]  w_host_idx;
  logic              w_unused_host;

  logic [BYTE_W-1:0] r_regs [DEPTH];

  i2c_in_filter #(.FILTER(FILTER)) u_scl_filter (
    .aclk    (aclk),
    .areset  (areset),
    .i_pad   (scl_in),
    .o_level (w_scl)
  );

  i2c_in_filter #(.FILTER(FILTER)) u_sda_filter (
    .aclk    (aclk),
    .areset  (areset),
    .i_pad   (sda_in),
    .o_level (w_sda)
  );

  // Bus events from the filtered lines.
  assign w_scl_rise = w_scl & ~r_scl_q;
  assign w_scl_fall = ~w_scl & r_scl_q;
  assign w_start    = r_scl_q & w_scl & r_sda_q & ~w_sda;
  assign w_stop     = r_scl_q & w_scl & ~r_sda_q & w_sda;

  assign w_rd_data     = r_regs[r_ptr];
  assign w_host_idx    = host_addr[PTR_W-1:0];
  assign w_unused_host = ^host_addr;

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_rw_nxt       = r_rw;
    w_ptr_nxt      = r_ptr;
    w_wr_index_nxt = r_wr_index;
    w_commit       = 1'b0;
    w_rd_load      = 1'b0;

    if (w_stop) begin
      w_state_nxt  = S_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_bitcnt_nxt = '0;
    end else if (w_start) begin
      w_state_nxt  = S_ADDR;
      w_sda_oe_nxt = 1'b0;
      w_bitcnt_nxt = '0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt  = {r_shift[BYTE_W-2:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
          end else if (w_scl_fall && r_bitcnt == CNT_W'(BYTE_W)) begin
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b1;
            if (r_state == S_ADDR) begin
              if (addr_match(r_shift, TARGET_ADDR)) begin
                w_busy_nxt  = 1'b1;
                w_rw_nxt    = r_shift[0];
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_sda_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_state_nxt  = S_IDLE;
              end
            end else if (r_state == S_PTR) begin
              w_ptr_nxt   = r_shift[PTR_W-1:0];
              w_state_nxt = S_PTR_ACK;
            end else begin
              w_commit       = 1'b1;
              w_wr_index_nxt = BYTE_W'(r_ptr);
              w_ptr_nxt      = r_ptr + PTR_W'(1);
              w_state_nxt    = S_WR_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = '0;
            if (r_rw) w_rd_load = 1'b1;
            else      w_state_nxt = S_PTR;
          end
        end
        S_PTR_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            w_sda_oe_nxt = 1'b0;
            w_bitcnt_nxt = '0;
            w_state_nxt  = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          // Bit 7 went out on entry; falls 1..7 shift out bits 6..0, fall 8 releases.
          if (w_scl_fall) begin
            if (r_bitcnt == CNT_W'(BYTE_W - 1)) begin
              w_sda_oe_nxt = 1'b0;
              w_bitcnt_nxt = '0;
              w_state_nxt  = S_RD_ACK;
            end else begin
              w_sda_oe_nxt = ~r_tx[BYTE_W-2];
              w_tx_nxt     = {r_tx[BYTE_W-3:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + CNT_W'(1);
            end
          end
        end
        S_RD_ACK: begin
          // A fall can only follow the ACK-bit rise, so reaching it means master ACK.
          if (w_scl_rise && w_sda) w_state_nxt = S_IDLE;
          else if (w_scl_fall)     w_rd_load   = 1'b1;
        end
        default: ;
      endcase
    end

    // Latch the next read byte, advance the pointer and drive its MSB.
    if (w_rd_load) begin
      w_tx_nxt     = w_rd_data[BYTE_W-2:0];
      w_sda_oe_nxt = ~w_rd_data[BYTE_W-1];
      w_ptr_nxt    = r_ptr + PTR_W'(1);
      w_bitcnt_nxt = '0;
      w_state_nxt  = S_RD_BYTE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= S_IDLE;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_rw       <= 1'b0;
      r_ptr      <= '0;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_scl_q    <= w_scl;
      r_sda_q    <= w_sda;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_rw       <= w_rw_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wr_pulse <= w_commit;
      r_wr_index <= w_wr_index_nxt;
    end
  end

  // Register file; an I2C commit beats a host write to the same index.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (w_commit && r_ptr == PTR_W'(i))             r_regs[i] <= r_shift;
        else if (host_we && w_host_idx == PTR_W'(i))    r_regs[i] <= host_wdata;
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_pulse   = r_wr_pulse;
  assign wr_index   = r_wr_index;
  assign host_rdata = r_regs[w_host_idx];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Purpose: directed bench for i2c_target_regs acting as bus master and host.
module tb_i2c_target_regs;

  localparam int unsigned FILTER = 3;
  localparam int unsigned Q      = 10;

  logic       aclk = 1'b0;
  logic       areset;
  logic       scl;
  logic       m_sda;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_we;
  logic [7:0] host_rdata;
  logic       busy;
  logic       wr_pulse;
  logic [7:0] wr_index;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_wr_q [$];
  logic [7:0] exp_rd_q [$];

  assign sda_in = m_sda & ~sda_oe;

  always #5 aclk = ~aclk;

  i2c_target_regs #(
    .TARGET_ADDR (7'h50),
    .DEPTH       (16),
    .FILTER      (FILTER)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .scl_in     (scl),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_we    (host_we),
    .host_rdata (host_rdata),
    .busy       (busy),
    .wr_pulse   (wr_pulse),
    .wr_index   (wr_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each I2C register write must match the next expected index.
  always @(negedge aclk) begin : wr_mon
    logic [7:0] e;
    if (wr_pulse === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        check("wr_unexpected", 32'(wr_pulse), 32'd0);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_index", 32'(wr_index), 32'(e));
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    hold(Q);
    scl = 1'b1;
    hold(Q);
    s = sda_in;
    hold(Q);
    scl = 1'b0;
    hold(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    hold(Q);
    scl = 1'b1;
    hold(Q);
    m_sda = 1'b0;
    hold(Q);
    scl = 1'b0;
    hold(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    hold(Q);
    scl = 1'b1;
    hold(Q);
    m_sda = 1'b1;
    hold(Q);
  endtask

  // coll_idx >= 0 fires a host write in the cycle the target commits this byte.
  task automatic write_byte(input logic [7:0] b, input int coll_idx,
                            input logic [7:0] coll_data, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i];
      hold(Q);
      scl = 1'b1;
      hold(2 * Q);
      scl = 1'b0;
      if (i == 0 && coll_idx >= 0) begin
        hold(2 + FILTER);
        host_addr  = 8'(coll_idx);
        host_wdata = coll_data;
        host_we    = 1'b1;
        hold(1);
        host_we = 1'b0;
        check("coll_align", 32'(wr_pulse), 32'd1);
        hold(Q - 3 - FILTER);
      end else begin
        hold(Q);
      end
    end
    clk_bit(1'b1, ack);
  endtask

  task automatic wr(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    write_byte(b, -1, 8'h00, ack);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic rd(input logic nack, input string tag);
    logic [7:0] d;
    logic       s;
    logic [7:0] e;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
    e = exp_rd_q.pop_front();
    check(tag, 32'(d), 32'(e));
  endtask

  task automatic check_reg(input int idx, input logic [7:0] exp, input string tag);
    host_addr = 8'(idx);
    #1;
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  task automatic host_write(input int idx, input logic [7:0] d);
    host_addr  = 8'(idx);
    host_wdata = d;
    host_we    = 1'b1;
    hold(1);
    host_we = 1'b0;
  endtask

  initial begin
    logic ack;
    scl        = 1'b1;
    m_sda      = 1'b1;
    host_we    = 1'b0;
    host_addr  = 8'h00;
    host_wdata = 8'h00;
    areset     = 1'b1;
    hold(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
    check("rst_wr_index", 32'(wr_index), 32'd0);
    check_reg(0, 8'h00, "rst_reg0");
    areset = 1'b0;
    hold(4);

    // Write burst starting at register 3.
    i2c_start();
    wr(8'hA0, 1'b0, "t1_addr_ack");
    check("t1_busy", 32'(busy), 32'd1);
    wr(8'h03, 1'b0, "t1_ptr_ack");
    exp_wr_q.push_back(8'd3);
    wr(8'h11, 1'b0, "t1_d0_ack");
    exp_wr_q.push_back(8'd4);
    wr(8'h22, 1'b0, "t1_d1_ack");
    i2c_stop();
    check("t1_busy_stop", 32'(busy), 32'd0);
    check("t1_pulses", 32'(exp_wr_q.size()), 32'd0);
    check_reg(3, 8'h11, "t1_reg3");
    check_reg(4, 8'h22, "t1_reg4");

    // Pointer set, repeated START, read with ACK then NACK.
    host_write(5, 8'h5A);
    i2c_start();
    wr(8'hA0, 1'b0, "t2_addr_ack");
    wr(8'h03, 1'b0, "t2_ptr_ack");
    i2c_start();
    wr(8'hA1, 1'b0, "t2_rd_addr_ack");
    exp_rd_q.push_back(8'h11);
    rd(1'b0, "t2_rd0");
    exp_rd_q.push_back(8'h22);
    rd(1'b1, "t2_rd1");
    check("t2_release", 32'(sda_oe), 32'd0);
    check("t2_busy_nack", 32'(busy), 32'd1);
    i2c_start();
    wr(8'hA1, 1'b0, "t2_rd2_addr_ack");
    exp_rd_q.push_back(8'h5A);
    rd(1'b1, "t2_rd_ptr5");
    i2c_stop();
    check("t2_busy_stop", 32'(busy), 32'd0);

    // Wrong address: no ACK, no writes.
    i2c_start();
    wr(8'hA2, 1'b1, "t3_nack");
    check("t3_busy", 32'(busy), 32'd0);
    wr(8'h44, 1'b1, "t3_silent");
    i2c_stop();
    check_reg(3, 8'h11, "t3_reg3");
    check_reg(4, 8'h22, "t3_reg4");

    // Pointer wrap at DEPTH.
    i2c_start();
    wr(8'hA0, 1'b0, "t4_addr_ack");
    wr(8'h0F, 1'b0, "t4_ptr_ack");
    exp_wr_q.push_back(8'd15);
    wr(8'hAA, 1'b0, "t4_d0_ack");
    exp_wr_q.push_back(8'd0);
    wr(8'hBB, 1'b0, "t4_d1_ack");
    i2c_stop();
    check_reg(15, 8'hAA, "t4_reg15");
    check_reg(0, 8'hBB, "t4_reg0");

    // Collisions: same index (I2C wins), different index (both land).
    i2c_start();
    wr(8'hA0, 1'b0, "t5_addr_ack");
    wr(8'h05, 1'b0, "t5_ptr_ack");
    exp_wr_q.push_back(8'd5);
    write_byte(8'h66, 5, 8'h55, ack);
    check("t5_d0_ack", 32'(ack), 32'd0);
    exp_wr_q.push_back(8'd6);
    write_byte(8'h77, 9, 8'h99, ack);
    check("t5_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    check_reg(5, 8'h66, "t5_reg5");
    check_reg(6, 8'h77, "t5_reg6");
    check_reg(9, 8'h99, "t5_reg9");

    // STOP mid-byte, then a short SDA glitch while SCL is high.
    i2c_start();
    wr(8'hA0, 1'b0, "t6_addr_ack");
    wr(8'h08, 1'b0, "t6_ptr_ack");
    for (int i = 0; i < 4; i++) begin
      m_sda = (i < 2);
      hold(Q);
      scl = 1'b1;
      hold(2 * Q);
      scl = 1'b0;
      hold(Q);
    end
    i2c_stop();
    hold(Q);
    m_sda = 1'b0;
    hold(1);
    m_sda = 1'b1;
    hold(4 * Q);
    check("t6_busy", 32'(busy), 32'd0);
    check_reg(8, 8'h00, "t6_reg8");
    scl = 1'b0;
    hold(Q);
    wr(8'hA0, 1'b1, "t6_idle_nack");

    // Asynchronous reset while driving read data.
    i2c_start();
    wr(8'hA0, 1'b0, "t7_addr_ack");
    wr(8'h03, 1'b0, "t7_ptr_ack");
    i2c_start();
    wr(8'hA1, 1'b0, "t7_rd_addr_ack");
    check("t7_driving", 32'(sda_oe), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check("t7_async_release", 32'(sda_oe), 32'd0);
    check("t7_busy", 32'(busy), 32'd0);
    scl   = 1'b1;
    m_sda = 1'b1;
    for (int i = 0; i < 16; i++) check_reg(i, 8'h00, "t7_reg_clear");
    hold(2);
    areset = 1'b0;
    hold(4);

    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
